keypad_scanner: RTL and testbench

//  Input-side companion to the multiplexed 7-seg display driver: scans a 4x4 matrix

---
 rtl/keypad_scanner.sv | 227 ++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad one active-low column at a time, samples the
//   active-low rows, debounces whole-keypad scan results and delivers one
//   4-bit key code per press over a valid/ready handshake.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous to clk
//   col_out    out  [3:0] column drive, active-low one-hot
//   key_code   out  [3:0] {row_idx, col_idx} of the last delivered press
//   key_valid  out  key_code holds an event not yet taken by the consumer
//   key_ready  in   consumer accepts the event
//   key_held   out  debounced state is exactly one key down
//   overrun    out  one-cycle pulse when a press event had to be dropped
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int                DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int                CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_SINGLE = 2'd1, CLS_MULTI = 2'd2} cls_t;
  typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

  // Two-flop synchroniser; idle rows read as all ones (pulled up).
  logic [3:0] r_row_s1, r_row_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
    end
  end

  // Column scan. r_keys accumulates the pressed keys of columns already
  // sampled in the current scan; column 3 is merged combinationally so the
  // classification is available on the scan's final cycle.
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [15:0]      r_keys;
  logic             w_col_last;
  logic             w_scan_end;
  logic [15:0]      w_col_hits;
  logic [15:0]      w_scan_keys;

  assign w_col_last = (r_div == DIV_LAST);
  assign w_scan_end = w_col_last && (r_col == 2'd3);
  assign col_out    = ~(4'b0001 << r_col);

  always_comb begin
    w_col_hits = '0;
    for (int r = 0; r < 4; r++) begin
      w_col_hits[{2'(r), r_col}] = ~r_row_s2[r];
    end
    w_scan_keys = r_keys | w_col_hits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_col  <= 2'd0;
      r_keys <= '0;
    end else if (w_col_last) begin
      r_div  <= '0;
      r_col  <= r_col + 2'd1;
      r_keys <= w_scan_end ? '0 : w_scan_keys;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  // Classification of the completed scan. Code is forced to 0 unless
  // exactly one key is down so candidates compare cleanly.
  cls_t       w_cls;
  logic [3:0] w_cls_code;
  logic [4:0] w_ones;
  logic [3:0] w_last_idx;

  always_comb begin
    w_ones     = '0;
    w_last_idx = '0;
    for (int k = 0; k < 16; k++) begin
      if (w_scan_keys[k]) begin
        w_ones     = w_ones + 5'd1;
        w_last_idx = 4'(k);
      end
    end
    if (w_ones == 5'd0) begin
      w_cls      = CLS_NONE;
      w_cls_code = 4'd0;
    end else if (w_ones == 5'd1) begin
      w_cls      = CLS_SINGLE;
      w_cls_code = w_last_idx;
    end else begin
      w_cls      = CLS_MULTI;
      w_cls_code = 4'd0;
    end
  end

  // Debounce: count consecutive identical scans. MULTI pins the count at 0
  // so a chord can never become the stable state.
  cls_t             r_prev_cls;
  logic [3:0]       r_prev_code;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_stable_load;

  always_comb begin
    if (w_cls == CLS_MULTI) begin
      w_cnt_next = '0;
    end else if ((w_cls == r_prev_cls) && (w_cls_code == r_prev_code)) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end else begin
      w_cnt_next = CNT_W'(1);
    end
    w_stable_load = w_scan_end && (w_cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_cls  <= CLS_NONE;
      r_prev_code <= 4'd0;
      r_cnt       <= '0;
    end else if (w_scan_end) begin
      r_prev_cls  <= w_cls;
      r_prev_code <= w_cls_code;
      r_cnt       <= w_cnt_next;
    end
  end

  // Stable-state FSM. The state register is the debounced stable value:
  // IDLE = NONE, HELD = SINGLE(r_held_code). A press event fires on entry
  // to HELD or on a change of the held key.
  state_t     r_state, w_state_next;
  logic [3:0] r_held_code, w_held_code_next;
  logic       w_event;
  logic       r_event;
  logic [3:0] r_event_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_held_code  <= 4'd0;
      r_event      <= 1'b0;
      r_event_code <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_held_code  <= w_held_code_next;
      r_event      <= w_event;
      r_event_code <= w_cls_code;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_held_code_next = r_held_code;
    w_event          = 1'b0;
    if (w_stable_load) begin
      if (w_cls == CLS_SINGLE) begin
        w_state_next     = S_HELD;
        w_held_code_next = w_cls_code;
        w_event          = (r_state == S_IDLE) || (r_held_code != w_cls_code);
      end else begin
        w_state_next     = S_IDLE;
      end
    end
  end

  assign key_held = (r_state == S_HELD);

  // Handshake: a transfer happens on any edge where key_valid & key_ready.
  // key_valid rises only with a new code and stays high with key_code frozen
  // until that transfer; key_ready while key_valid is low has no effect. An
  // event arriving while the slot is full and not being emptied is dropped
  // and flagged by overrun; an event coinciding with a transfer refills it.
  logic r_key_valid;
  logic [3:0] r_key_code;
  logic r_overrun;
  logic w_xfer;

  assign w_xfer = r_key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_overrun   <= 1'b0;
    end else if (r_event) begin
      if (!r_key_valid || w_xfer) begin
        r_key_code  <= r_event_code;
        r_key_valid <= 1'b1;
        r_overrun   <= 1'b0;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else begin
      r_overrun <= 1'b0;
      if (w_xfer) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
//   (one full scan = 16 clocks). A keypad model turns the pressed-key set
//   into row levels from col_out. Expected key codes are queued when a press
//   is driven; a monitor collects each code the DUT presents and the main
//   sequence pops and compares them.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_held;
  logic       overrun;

  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ov_cnt   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  // keypad model: row r pulled low when a pressed key in row r sits on the
  // currently driven column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // monitor: a code is presented when key_valid rises or is refilled right
  // after a transfer
  initial begin
    logic prev_valid;
    logic prev_xfer;
    prev_valid = 1'b0;
    prev_xfer  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
      end else begin
        if (key_valid && (!prev_valid || prev_xfer)) obs_q.push_back(key_code);
        if (overrun) ov_cnt++;
        prev_valid = key_valid;
        prev_xfer  = key_valid & key_ready;
      end
    end
  end

  // driver / checker tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // returns 1 time unit after the second clock edge of a fresh scan
  task automatic align_scan();
    int budget;
    bit seen3;
    bit done;
    budget = 80;
    seen3  = 1'b0;
    done   = 1'b0;
    while (!done && budget > 0) begin
      @(negedge clk);
      budget--;
      if (seen3 && col_out == 4'b1110) done = 1'b1;
      seen3 = (col_out == 4'b0111);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $error("FAIL align_timeout: col_out 0x%0h never wrapped to 0xe", col_out);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
  endtask

  task automatic drain();
    logic [3:0] obs;
    logic [3:0] exp_v;
    @(negedge clk);
    #1;
    while (obs_q.size() > 0) begin
      obs = obs_q.pop_front();
      check("event_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        check("event_code", obs, exp_v);
      end
    end
  endtask

  // directed sequence
  initial begin
    logic [3:0] exp_col;

    #1 rst_n = 1'b0;
    #2;
    check("reset_col_out", col_out, 4'b1110);
    check("reset_flags", {key_code, key_valid, key_held, overrun}, 7'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle scanning
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (i / 4));
      check("idle_scan", {col_out, key_valid, key_held}, {exp_col, 2'b00});
    end

    // single press 0x9, no ready
    align_scan();
    keys = 16'h1 << 9;
    exp_q.push_back(4'h9);
    tick(31);
    check("t2_valid_latency", key_valid, 1'b0);
    check("t2_held", key_held, 1'b1);
    tick(1);
    check("t2_valid", key_valid, 1'b1);
    check("t2_code", key_code, 4'h9);
    drain();
    tick(160);
    check("t2_no_repeat", {key_valid, key_code}, {1'b1, 4'h9});
    check("t2_no_overrun", ov_cnt, 0);
    drain();

    // consume, release, re-press 0x0
    consume();
    check("t3_valid_cleared", key_valid, 1'b0);
    align_scan();
    keys = '0;
    tick(15);
    check("t3_held_one_none_scan", key_held, 1'b1);
    tick(16);
    check("t3_held_cleared", key_held, 1'b0);
    check("t3_no_release_event", key_valid, 1'b0);
    align_scan();
    keys = 16'h1;
    exp_q.push_back(4'h0);
    tick(32);
    check("t3_repress", {key_valid, key_code}, {1'b1, 4'h0});
    drain();
    consume();
    check("t3_consumed", key_valid, 1'b0);
    align_scan();
    keys = '0;
    tick(40);

    // bounce on key 0x6
    align_scan();
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? (16'h1 << 6) : 16'h0;
      tick(16);
    end
    check("t4_no_event_bouncing", key_valid, 1'b0);
    exp_q.push_back(4'h6);
    tick(15);
    check("t4_no_event_one_scan", key_valid, 1'b0);
    tick(1);
    check("t4_event", {key_valid, key_code}, {1'b1, 4'h6});
    drain();
    check("t4_no_overrun", ov_cnt, 0);
    consume();
    align_scan();
    keys = '0;
    tick(40);

    // overrun: 0x9 pending, then 0x3 pressed with no ready
    align_scan();
    keys = 16'h1 << 9;
    exp_q.push_back(4'h9);
    tick(32);
    check("t5_first", {key_valid, key_code}, {1'b1, 4'h9});
    drain();
    align_scan();
    keys = '0;
    tick(40);
    align_scan();
    keys = 16'h1 << 3;
    tick(32);
    check("t5_overrun_pulse", overrun, 1'b1);
    check("t5_code_kept", {key_valid, key_code}, {1'b1, 4'h9});
    tick(1);
    check("t5_overrun_one_cycle", overrun, 1'b0);
    drain();
    check("t5_overrun_count", ov_cnt, 1);
    consume();
    check("t5_consumed", key_valid, 1'b0);

    // event coinciding with transfer
    align_scan();
    keys = '0;
    tick(40);
    align_scan();
    keys = 16'h1 << 9;
    exp_q.push_back(4'h9);
    tick(32);
    check("t5b_first", {key_valid, key_code}, {1'b1, 4'h9});
    drain();
    align_scan();
    keys = '0;
    tick(40);
    align_scan();
    keys = 16'h1 << 3;
    exp_q.push_back(4'h3);
    tick(31);
    key_ready = 1'b1;
    tick(1);
    key_ready = 1'b0;
    check("t5b_refill", {key_valid, key_code, overrun}, {1'b1, 4'h3, 1'b0});
    drain();
    check("t5b_overrun_count", ov_cnt, 1);
    consume();
    check("t5b_consumed", key_valid, 1'b0);

    // chord 0x5 + 0x6
    align_scan();
    keys = '0;
    tick(40);
    align_scan();
    keys = (16'h1 << 5) | (16'h1 << 6);
    tick(64);
    check("t6_multi_no_event", {key_valid, key_held}, 2'b00);
    align_scan();
    keys = '0;
    tick(40);
    check("t6_after_chord", {key_valid, key_held}, 2'b00);

    // reset mid-scan with an event pending
    align_scan();
    keys = 16'h1 << 10;
    exp_q.push_back(4'hA);
    tick(32);
    check("t6_pending", {key_valid, key_code}, {1'b1, 4'hA});
    drain();
    align_scan();
    tick(5);
    rst_n = 1'b0;
    #2;
    check("t6_reset_col", col_out, 4'b1110);
    check("t6_reset_flags", {key_code, key_valid, key_held, overrun}, 7'd0);
    keys = '0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("t6_resume_col", col_out, 4'b1101);
    check("t6_resume_flags", {key_valid, key_held}, 2'b00);

    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
